// File: rtl/soc_pkg.sv
// Shared LED-mode encoding and the LED pattern helper used by the PC phase tracker.
package soc_pkg;

    typedef enum logic [1:0] {
        ONEHOT = 2'd0,
        THERMO = 2'd1,
        FREEZE = 2'd2
    } led_mode_e;

    // Bit idx of an n-wide LED bank showing phase p; phase 0 lights the MSB.
    function automatic logic led_bit(input int n, input int p, input int idx, input logic thermo);
        logic on;
        on = 1'b0;
        if (idx < n) begin
            if (thermo) begin
                on = (idx >= n - 1 - p);
            end else begin
                on = (idx == n - 1 - p);
            end
        end
        return on;
    endfunction

endpackage

// File: rtl/phase_filter.sv
// Dwell filter: a new phase is committed only after DWELL consecutive enabled samples agree.
module phase_filter
    import soc_pkg::*;
#(
    parameter int PW    = 4,
    parameter int DWELL = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          pc_en,
    input  logic [PW-1:0] raw,
    input  logic [PW-1:0] phase,
    output logic          commit,
    output logic [PW-1:0] cand
);

    localparam int DW = (DWELL < 2) ? 1 : $clog2(DWELL + 1);

    logic [PW-1:0] cand_q;
    logic [DW-1:0] dwell_q;
    logic [DW-1:0] dwell_d;
    logic [DW-1:0] run_len;

    // cand exposes the candidate as updated by this sample, so a DWELL=1 commit
    // can hand the top the new phase without waiting for cand_q.
    always_comb begin
        cand    = cand_q;
        dwell_d = dwell_q;
        run_len = '0;
        commit  = 1'b0;
        if (pc_en) begin
            if (raw == phase) begin
                dwell_d = '0;
            end else begin
                cand    = raw;
                run_len = (raw == cand_q) ? dwell_q + 1'b1 : DW'(1);
                if (run_len == DW'(DWELL)) begin
                    commit  = 1'b1;
                    dwell_d = '0;
                end else begin
                    dwell_d = run_len;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cand_q  <= '0;
            dwell_q <= '0;
        end else begin
            cand_q  <= cand;
            dwell_q <= dwell_d;
        end
    end

endmodule

// File: rtl/pc_phase_tracker.sv
// Classifies the core fetch address into program phases, filters short excursions,
// and keeps per-phase cycle counters, a lap counter and the LED bank drive.
module pc_phase_tracker
    import soc_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int NUM_PHASES = 10,
    parameter logic [NUM_PHASES-2:0][WIDTH-1:0] BOUNDS = {
        32'd2473, 32'd2411, 32'd2371, 32'd2179, 32'd2101,
        32'd2015, 32'd2005, 32'd1882, 32'd1870
    },
    parameter int DWELL      = 4,
    parameter int CNT_W      = 32
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          pc_en,
    input  logic [WIDTH-1:0]              programaddress,
    input  logic [1:0]                    mode,
    input  logic [$clog2(NUM_PHASES)-1:0] sel,
    output logic [NUM_PHASES-1:0]         led,
    output logic [$clog2(NUM_PHASES)-1:0] phase,
    output logic                          phase_strobe,
    output logic [CNT_W-1:0]              cycles,
    output logic [15:0]                   laps
);

    localparam int PW = $clog2(NUM_PHASES);

    logic [PW-1:0]         raw;
    logic [PW-1:0]         phase_q;
    logic [PW-1:0]         cand;
    logic                  commit;
    logic                  strobe_q;
    logic [15:0]           laps_q;
    logic [CNT_W-1:0]      cycles_q;
    logic [CNT_W-1:0]      cycles_d;
    logic [NUM_PHASES-1:0] led_q;
    logic [NUM_PHASES-1:0] led_d;
    logic [CNT_W-1:0]      counters [NUM_PHASES];

    // Word bounds are scaled to byte addresses; raw is the number of bounds passed.
    always_comb begin
        raw = '0;
        for (int i = 0; i < NUM_PHASES - 1; i++) begin
            if (programaddress >= (BOUNDS[i] << 2)) begin
                raw = raw + 1'b1;
            end
        end
    end

    phase_filter #(
        .PW    (PW),
        .DWELL (DWELL)
    ) u_filter (
        .clock  (clock),
        .reset  (reset),
        .pc_en  (pc_en),
        .raw    (raw),
        .phase  (phase_q),
        .commit (commit),
        .cand   (cand)
    );

    always_comb begin
        cycles_d = '0;
        for (int p = 0; p < NUM_PHASES; p++) begin
            if (sel == PW'(p)) begin
                cycles_d = counters[p];
            end
        end
    end

    // Freeze keeps the last picture; reserved mode 3 falls through to one-hot.
    always_comb begin
        led_d = led_q;
        if (mode != FREEZE) begin
            for (int i = 0; i < NUM_PHASES; i++) begin
                led_d[i] = led_bit(NUM_PHASES, int'(phase_q), i, mode == THERMO);
            end
        end
    end

    // Counters charge the phase held before any commit on the same sample.
    always_ff @(posedge clock) begin
        if (reset) begin
            phase_q  <= '0;
            strobe_q <= 1'b0;
            laps_q   <= '0;
            cycles_q <= '0;
            led_q    <= {1'b1, {(NUM_PHASES-1){1'b0}}};
            for (int p = 0; p < NUM_PHASES; p++) begin
                counters[p] <= '0;
            end
        end else begin
            strobe_q <= commit;
            cycles_q <= cycles_d;
            led_q    <= led_d;
            for (int p = 0; p < NUM_PHASES; p++) begin
                if (pc_en && (phase_q == PW'(p)) && (counters[p] != {CNT_W{1'b1}})) begin
                    counters[p] <= counters[p] + 1'b1;
                end
            end
            if (commit) begin
                phase_q <= cand;
                if ((cand < phase_q) && (laps_q != 16'hFFFF)) begin
                    laps_q <= laps_q + 16'd1;
                end
            end
        end
    end

    assign phase        = phase_q;
    assign phase_strobe = strobe_q;
    assign cycles       = cycles_q;
    assign laps         = laps_q;
    assign led          = led_q;

endmodule

// File: tb/tb_pc_phase_tracker.sv
// Scoreboard bench for pc_phase_tracker: directed scenarios then randomized address segments,
// checked against a history-window reference model (plus a CNT_W=4 instance for saturation).
module tb_pc_phase_tracker;

    localparam int DWELL = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        pc_en;
    logic [31:0] programaddress;
    logic [1:0]  mode;
    logic [3:0]  sel;

    logic [9:0]  led,    led_s;
    logic [3:0]  phase,  phase_s;
    logic        phase_strobe, phase_strobe_s;
    logic [31:0] cycles;
    logic [3:0]  cycles_s;
    logic [15:0] laps,   laps_s;

    pc_phase_tracker #(.DWELL(DWELL)) dut (
        .clock          (clock),
        .reset          (reset),
        .pc_en          (pc_en),
        .programaddress (programaddress),
        .mode           (mode),
        .sel            (sel),
        .led            (led),
        .phase          (phase),
        .phase_strobe   (phase_strobe),
        .cycles         (cycles),
        .laps           (laps)
    );

    pc_phase_tracker #(.DWELL(DWELL), .CNT_W(4)) dut_sat (
        .clock          (clock),
        .reset          (reset),
        .pc_en          (pc_en),
        .programaddress (programaddress),
        .mode           (mode),
        .sel            (sel),
        .led            (led_s),
        .phase          (phase_s),
        .phase_strobe   (phase_strobe_s),
        .cycles         (cycles_s),
        .laps           (laps_s)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [9:0]  led;
        logic [3:0]  phase;
        logic        strobe;
        logic [31:0] cycles;
        logic [3:0]  cycles_sat;
        logic [15:0] laps;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    int          bnd [9] = '{1870, 1882, 2005, 2015, 2101, 2179, 2371, 2411, 2473};
    int          m_phase;
    int          m_laps;
    int unsigned m_cnt [10];
    logic [9:0]  m_led;
    int          m_hist[$];

    function automatic int classify(input logic [31:0] a);
        int r = 0;
        foreach (bnd[i]) begin
            if (a >= 32'(bnd[i] * 4)) r++;
        end
        return r;
    endfunction

    function automatic logic [9:0] pattern(input int p, input logic [1:0] md);
        if (md == 2'd1) return 10'((1 << (p + 1)) - 1) << (9 - p);
        return 10'(1 << (9 - p));
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    // Drive one cycle of inputs and push what the DUT must show after the next edge.
    task automatic apply_stimulus(input logic r, input logic en, input logic [31:0] a,
                                  input logic [1:0] md, input logic [3:0] s);
        exp_t e;
        int   raw;
        bit   same;
        @(negedge clock);
        reset = r; pc_en = en; programaddress = a; mode = md; sel = s;
        e.strobe = 1'b0;
        if (r) begin
            m_phase = 0;
            m_laps  = 0;
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_led = 10'h200;
            m_hist.delete();
            e.cycles = 0;
            e.cycles_sat = 0;
        end else begin
            e.cycles     = (s < 10) ? m_cnt[s] : 0;
            e.cycles_sat = (e.cycles > 15) ? 4'd15 : e.cycles[3:0];
            if (md != 2'd2) m_led = pattern(m_phase, md);
            if (en) begin
                if (m_cnt[m_phase] != 32'hFFFF_FFFF) m_cnt[m_phase]++;
                raw = classify(a);
                m_hist.push_back(raw);
                if (m_hist.size() > DWELL) void'(m_hist.pop_front());
                if (raw != m_phase && m_hist.size() == DWELL) begin
                    same = 1'b1;
                    foreach (m_hist[i]) if (m_hist[i] != raw) same = 1'b0;
                    if (same) begin
                        e.strobe = 1'b1;
                        if (raw < m_phase && m_laps < 65535) m_laps++;
                        m_phase = raw;
                    end
                end
            end
        end
        e.led   = m_led;
        e.phase = 4'(m_phase);
        e.laps  = 16'(m_laps);
        sb.push_back(e);
    endtask

    task automatic hold(input int n, input logic r, input logic en, input logic [31:0] a,
                        input logic [1:0] md, input logic [3:0] s);
        for (int k = 0; k < n; k++) apply_stimulus(r, en, a, md, s);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_output("led",        32'(led),           32'(e.led));
                check_output("phase",      32'(phase),         32'(e.phase));
                check_output("strobe",     32'(phase_strobe),  32'(e.strobe));
                check_output("cycles",     cycles,             e.cycles);
                check_output("laps",       32'(laps),          32'(e.laps));
                check_output("sat_cycles", 32'(cycles_s),      32'(e.cycles_sat));
                check_output("sat_phase",  32'(phase_s),       32'(e.phase));
                check_output("sat_led",    32'(led_s),         32'(e.led));
                check_output("sat_strobe", 32'(phase_strobe_s), 32'(e.strobe));
                check_output("sat_laps",   32'(laps_s),        32'(e.laps));
            end
        end
    end

    initial begin : driver
        logic [31:0] a;
        int          k;
        int unsigned lo, hi;
        logic [1:0]  md;
        reset = 1'b1; pc_en = 1'b0; programaddress = '0; mode = 2'd0; sel = '0;

        hold(2, 1'b1, 1'b1, 32'd0, 2'd0, 4'd0);
        hold(21, 1'b0, 1'b1, 32'd0, 2'd0, 4'd0);
        hold(6, 1'b0, 1'b1, 32'd7480, 2'd0, 4'd1);
        hold(3, 1'b0, 1'b1, 32'd8020, 2'd0, 4'd3);
        hold(3, 1'b0, 1'b1, 32'd7480, 2'd0, 4'd1);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b0, 1'b1, 32'd8060, 2'd0, 4'd1);
            apply_stimulus(1'b0, 1'b0, 32'd8060, 2'd0, 4'd4);
        end
        hold(2, 1'b0, 1'b1, 32'd8060, 2'd0, 4'd4);
        hold(6, 1'b0, 1'b1, 32'd9892, 2'd1, 4'd9);
        hold(6, 1'b0, 1'b1, 32'd0, 2'd1, 4'd9);
        hold(6, 1'b0, 1'b1, 32'd8404, 2'd2, 4'd5);
        hold(6, 1'b0, 1'b1, 32'd0, 2'd2, 4'd5);
        hold(2, 1'b0, 1'b1, 32'd0, 2'd0, 4'd0);
        hold(20, 1'b0, 1'b1, 32'd0, 2'd0, 4'd0);
        hold(1, 1'b1, 1'b1, 32'd0, 2'd0, 4'd0);
        hold(3, 1'b0, 1'b1, 32'd0, 2'd0, 4'd0);

        for (int seg = 0; seg < 3000; seg++) begin
            k = $urandom_range(0, 9);
            if ($urandom_range(0, 9) == 0) begin
                a = $urandom();
            end else begin
                lo = (k == 0) ? 0 : bnd[k-1] * 4;
                hi = (k == 9) ? bnd[8] * 4 + 400 : bnd[k] * 4 - 1;
                a  = ($urandom_range(0, 3) == 0) ? lo : $urandom_range(lo, hi);
            end
            md = 2'($urandom_range(0, 3));
            for (int c = 0; c < $urandom_range(1, 7); c++) begin
                apply_stimulus($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
                               a, md, 4'($urandom_range(0, 15)));
            end
        end

        @(posedge clock);
        #4;
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL drain: %0d expected entries left, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
